// File: rtl/hash_pkg.sv
// Shared types, default constants and round function for param_hash_engine.
// The rotl/add/xor round is written once here and reused by datapath and bench.
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } hash_state_t;

  localparam int HASH_MAX_W = 64;

  localparam logic [31:0] HASH_IV  = 32'h6A09E667;
  localparam logic [31:0] HASH_RC  = 32'h9E3779B9;
  localparam int          HASH_ROT = 5;

  // One round at width w (w <= HASH_MAX_W): rotl(h + m, rot) ^ rc, mod 2^w.
  function automatic logic [HASH_MAX_W-1:0] hash_round(
    input logic [HASH_MAX_W-1:0] h,
    input logic [HASH_MAX_W-1:0] m,
    input int                    w   = 32,
    input int                    rot = HASH_ROT,
    input logic [HASH_MAX_W-1:0] rc  = HASH_MAX_W'(HASH_RC)
  );
    logic [HASH_MAX_W-1:0] mask;
    logic [HASH_MAX_W-1:0] s;
    logic [HASH_MAX_W-1:0] r;
    if (w >= HASH_MAX_W) mask = '1;
    else mask = (HASH_MAX_W'(1) << w) - HASH_MAX_W'(1);
    s = (h + m) & mask;
    r = ((s << rot) | (s >> (w - rot))) & mask;
    return (r ^ rc) & mask;
  endfunction

endpackage

// File: rtl/hash_round_core.sv
// Combinational round datapath: next H from current H and one message word.
// Message word is zero-extended to the digest width before the add.
module hash_round_core
  import hash_pkg::*;
#(
  parameter int                  DATA_W   = 8,
  parameter int                  DIGEST_W = 32,
  parameter int                  ROT      = HASH_ROT,
  parameter logic [DIGEST_W-1:0] RC       = DIGEST_W'(HASH_RC)
) (
  input  logic [DIGEST_W-1:0] h,
  input  logic [DATA_W-1:0]   m,
  output logic [DIGEST_W-1:0] h_next
);

  assign h_next = DIGEST_W'(hash_round(
    HASH_MAX_W'(h), HASH_MAX_W'(m), DIGEST_W, ROT, HASH_MAX_W'(RC)));

endmodule

// File: rtl/param_hash_engine.sv
// Streaming length-prefixed hash core with held digest output.
// Optional HASH_CHAIN_EN adds chain_i to seed H from the previous digest.
module param_hash_engine
  import hash_pkg::*;
#(
  parameter int                  DATA_W   = 8,
  parameter int                  DIGEST_W = 32,
  parameter int                  LEN_W    = 64,
  parameter int                  ROT      = HASH_ROT,
  parameter logic [DIGEST_W-1:0] IV       = DIGEST_W'(HASH_IV),
  parameter logic [DIGEST_W-1:0] RC       = DIGEST_W'(HASH_RC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
`ifdef HASH_CHAIN_EN
  input  logic                chain_i,
`endif
  input  logic [LEN_W-1:0]    len_i,
  input  logic                msg_valid_i,
  input  logic [DATA_W-1:0]   msg_i,
  output logic                msg_ready_o,
  output logic                busy_o,
  output logic                digest_valid_o,
  output logic [DIGEST_W-1:0] digest_o,
  input  logic                digest_ack_i
);

  hash_state_t         state;
  logic [DIGEST_W-1:0] h;
  logic [DIGEST_W-1:0] h_rnd;
  logic [DIGEST_W-1:0] h_init;
  logic [DIGEST_W-1:0] h_fin;
  logic [DIGEST_W-1:0] digest;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len_q;
  logic                msg_ready;
  logic                busy;
  logic                digest_valid;

  hash_round_core #(
    .DATA_W  (DATA_W),
    .DIGEST_W(DIGEST_W),
    .ROT     (ROT),
    .RC      (RC)
  ) u_round (
    .h     (h),
    .m     (msg_i),
    .h_next(h_rnd)
  );

`ifdef HASH_CHAIN_EN
  assign h_init = chain_i ? digest : IV;
`else
  assign h_init = IV;
`endif

  // Length folds in truncated or zero-extended to the digest width.
  assign h_fin = h ^ DIGEST_W'(len_q);

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      h            <= '0;
      cnt          <= '0;
      len_q        <= '0;
      digest       <= '0;
      msg_ready    <= 1'b0;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            len_q <= len_i;
            h     <= h_init;
            cnt   <= '0;
            busy  <= 1'b1;
            if (len_i == '0) begin
              state <= FINAL;
            end else begin
              state     <= ABSORB;
              msg_ready <= 1'b1;
            end
          end
        end
        ABSORB: begin
          if (msg_valid_i) begin
            h   <= h_rnd;
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              state     <= FINAL;
              msg_ready <= 1'b0;
            end
          end
        end
        FINAL: begin
          h      <= h_fin;
          digest <= h_fin;
          state  <= DONE;
        end
        DONE: begin
          if (!digest_valid) begin
            digest_valid <= 1'b1;
          end else if (digest_ack_i) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign msg_ready_o    = msg_ready;
  assign busy_o         = busy;
  assign digest_valid_o = digest_valid;
  assign digest_o       = digest;

endmodule
